fp_add_arbiter: RTL and testbench

Round-robin arbiter that shares one single-precision floating-point adder (the team's FloatingAddition datapath) among NREQ requesters. Each requester has a valid/ready request channel. Granted operands drive the adder combinationally, and the sum is captured in a single output register with a valid/ready response channel, a requester tag and the adder flags. The block sits between the vector-op issue logic and the shared adder instance, which stays outside this block.

---
 rtl/fp_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/fp_add_arbiter.sv | 100 ++++++++++
 tb/tb_fp_add_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder sharing logic: widths, constants,
// flag bit positions and the response-register state encoding.
package fp_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  // Bit positions inside the 3-bit {exc, unf, ovf} flag vector.
  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_EXC = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit after 'last',
// wrapping modulo N. Reusable by any arbiter in front of a shared datapath.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // NOTE: every output gets a default before the loop so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    any    = 1'b0;
    onehot = '0;
    idx    = IW'((int'(last) + 1) % N);
    // Walk from the lowest priority (last itself) up to last+1 so the highest
    // priority hit is the one written last.
    for (int i = N; i >= 1; i--) begin
      int k;
      k = (int'(last) + i) % N;
      if (req[k]) begin
        any    = 1'b1;
        onehot = N'(1) << k;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin front end for one shared single-precision adder: grants one requester
// per cycle, feeds its operands to the adder and registers the sum with tag and flags.
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int XLEN = fp_pkg::XLEN,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [XLEN-1:0]    add_a,
  output logic [XLEN-1:0]    add_b,
  input  logic [XLEN-1:0]    add_result,
  input  logic               add_ovf,
  input  logic               add_unf,
  input  logic               add_exc,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_result,
  output logic [IDW-1:0]     rsp_id,
  output logic [2:0]         rsp_flags,
  output logic [CNTW-1:0]    op_count
);

  rsp_state_t      state, state_next;
  logic [IDW-1:0]  last_grant;
  logic            win_any;
  logic [NREQ-1:0] win_onehot;
  logic [IDW-1:0]  win_idx;
  logic            can_accept;
  logic            accept;
  logic            drain;
  logic [2:0]      flags_in;

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .req    (req_valid),
    .last   (last_grant),
    .any    (win_any),
    .onehot (win_onehot),
    .idx    (win_idx)
  );

  assign rsp_valid  = (state == FULL);
  assign drain      = rsp_valid & rsp_ready;
  // A full register can still take a new sum when the old one leaves this edge.
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign accept     = ~rst & can_accept & win_any;
  assign req_ready  = accept ? win_onehot : '0;

  assign add_a = req_a[win_idx*XLEN +: XLEN];
  assign add_b = req_b[win_idx*XLEN +: XLEN];

  always_comb begin
    flags_in           = '0;
    flags_in[FLAG_OVF] = add_ovf;
    flags_in[FLAG_UNF] = add_unf;
    flags_in[FLAG_EXC] = add_exc;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (drain && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      last_grant <= IDW'(NREQ - 1);
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_flags  <= '0;
      op_count   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        rsp_result <= add_result;
        rsp_flags  <= flags_in;
        rsp_id     <= win_idx;
        last_grant <= win_idx;
      end
      if (drain) op_count <= op_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomised and directed bench for fp_add_arbiter with a stand-in adder and a
// transaction-level reference model of grants and responses.
module tb_fp_add_arbiter;
  import fp_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*32-1:0]   req_a, req_b;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          add_a, add_b, add_result;
  logic                 add_ovf, add_unf, add_exc;
  logic                 rsp_valid, rsp_ready;
  logic [31:0]          rsp_result;
  logic [IDW-1:0]       rsp_id;
  logic [2:0]           rsp_flags;
  logic [CNTW-1:0]      op_count;

  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_full;
  logic [31:0] m_result;
  logic [2:0]  m_flags;
  int          m_id;
  int          m_last;
  logic [15:0] m_count;

  always #5 clk = ~clk;

  // Stand-in for the external adder: exact sums for the directed operand pairs,
  // a cheap deterministic mix with flags elsewhere.
  function automatic logic [34:0] fp_stub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [2:0]  f;
    if (a == FP_ONE && b == FP_ONE)                  r = 32'h4000_0000;
    else if (a == 32'h3FC0_0000 && b == 32'h4020_0000) r = 32'h4080_0000;
    else                                             r = a + b;
    f = {a[31] & b[31], a[1] ^ b[2], r[0] & a[3]};
    return {f, r};
  endfunction

  assign {add_exc, add_unf, add_ovf, add_result} = fp_stub(add_a, add_b);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = op_a[i];
      req_b[i*32 +: 32] = op_b[i];
    end
  end

  fp_add_arbiter #(.XLEN(32), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .add_ovf    (add_ovf),
    .add_unf    (add_unf),
    .add_exc    (add_exc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_flags  (rsp_flags),
    .op_count   (op_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (v[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_result = '0; m_flags = '0; m_id = 0; m_last = NREQ - 1; m_count = '0;
  endtask

  // Called at a falling edge with inputs already set; checks, crosses one rising
  // edge, updates the model and retires the accepted request (unless refill).
  task automatic cycle(input bit refill);
    int g;
    bit can, acc;
    logic [NREQ-1:0] er;
    #1;
    can = !m_full || rsp_ready;
    g   = pick(req_valid, m_last);
    acc = !rst && can && (g >= 0);
    er  = acc ? (NREQ'(1) << g) : '0;
    check("req_ready", 64'(req_ready), 64'(er));
    check("rsp_valid", 64'(rsp_valid), 64'(m_full));
    check("rsp_result", 64'(rsp_result), 64'(m_result));
    check("rsp_id", 64'(rsp_id), 64'(m_id));
    check("rsp_flags", 64'(rsp_flags), 64'(m_flags));
    check("op_count", 64'(op_count), 64'(m_count));
    if (acc) begin
      check("add_a", 64'(add_a), 64'(op_a[g]));
      check("add_b", 64'(add_b), 64'(op_b[g]));
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_full && rsp_ready) begin
        m_count++;
        m_full = 0;
      end
      if (acc) begin
        {m_flags, m_result} = fp_stub(op_a[g], op_b[g]);
        m_id   = g;
        m_full = 1;
        m_last = g;
        if (!refill) req_valid[g] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [15:0] cnt_before;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = FP_ONE;
      op_b[i] = FP_ONE;
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset held with all requests valid: nothing is accepted.
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b0;
    // First cycle after reset grants requester 0 (1.0 + 1.0).
    cycle(1'b0);
    req_valid = '0;
    #1;
    check("single_result", 64'(rsp_result), 64'h4000_0000);
    check("single_id", 64'(rsp_id), 64'd0);
    check("single_flags", 64'(rsp_flags), 64'd0);
    cycle(1'b0);
    #1;
    check("single_count", 64'(op_count), 64'd1);

    // Streaming: all requesters continuously valid, one grant per cycle.
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'h3FC0_0000;
      op_b[i] = 32'h4020_0000;
    end
    req_valid = '1;
    for (int n = 0; n < 9; n++) cycle(1'b1);
    #1;
    check("stream_result", 64'(rsp_result), 64'h4080_0000);
    req_valid = '0;
    cycle(1'b0);

    // Backpressure, then drain and accept on the same edge.
    req_valid = 4'b0001;
    cycle(1'b0);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int n = 0; n < 3; n++) cycle(1'b0);
    rsp_ready = 1'b1;
    cycle(1'b0);
    #1;
    check("bp_id", 64'(rsp_id), 64'd1);
    check("bp_valid", 64'(rsp_valid), 64'd1);

    // Fairness: after a grant to 2, requester 3 goes before 1.
    req_valid = 4'b0100;
    cycle(1'b0);
    req_valid = 4'b1010;
    cycle(1'b0);
    #1;
    check("fair_first", 64'(rsp_id), 64'd3);
    cycle(1'b0);
    #1;
    check("fair_second", 64'(rsp_id), 64'd1);
    cycle(1'b0);

    // Reset mid-operation with a pending response.
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    cycle(1'b0);
    rst = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    #1;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_count", 64'(op_count), 64'd0);
    check("rst_grant", 64'(req_ready), 64'b0001);
    cycle(1'b0);

    // Random traffic, backpressure and occasional resets against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          op_a[i] = $urandom;
          op_b[i] = $urandom;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 80) == 0);
      cycle(1'b0);
    end
    rst = 1'b0;

    // Drain remaining traffic and confirm the counter tracked every handshake.
    req_valid = '0;
    rsp_ready = 1'b1;
    cnt_before = m_count;
    cycle(1'b0);
    cycle(1'b0);
    #1;
    check("final_count", 64'(op_count), 64'(m_count));
    check("final_valid", 64'(rsp_valid), 64'd0);
    check("final_count_monotonic", 64'(op_count - cnt_before), 64'(m_count - cnt_before));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
